// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP word
// and default widths.
package if_fetch_stage_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_INSTR_W = 32;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load enable plus synchronous clear (clear wins),
// asynchronous active-low reset to an empty NOP slot.
module if_id_reg #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ld_i,
  input  logic               clr_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc4_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc4_o,
  output logic               valid_o
);
  import if_fetch_stage_pkg::*;

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc4_q;
  logic               valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= INSTR_W'(NOP);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      instr_q <= INSTR_W'(NOP);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (ld_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem request FSM, a
// one-entry skid buffer for responses that land during a stall, and IF/ID.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned     ADDR_W   = DEF_ADDR_W,
  parameter int unsigned     INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic [ADDR_W-1:0]  if_id_pc_plus4,
  output logic               if_id_valid
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] skid_q, skid_d;

  logic               ifid_ld, ifid_clr;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  pc_plus4, redir_tgt;
  logic [1:0]         unused_redir_lsb;

  assign pc_plus4         = pc_q + ADDR_W'(4);
  assign redir_tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redir_lsb = redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= {RESET_PC[ADDR_W-1:2], 2'b00};
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    ifid_ld    = 1'b0;
    ifid_clr   = 1'b0;
    ifid_instr = imem_rdata;
    imem_req   = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
        if (redirect_valid) pc_d = redir_tgt;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          // Request can't be withdrawn: without its response yet, drain it.
          pc_d     = redir_tgt;
          ifid_clr = 1'b1;
          skid_d   = '0;
          state_d  = imem_rvalid ? ST_FETCH : ST_DRAIN;
        end else if (imem_rvalid) begin
          if (pc_write) begin
            ifid_ld = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d     = redir_tgt;
          ifid_clr = 1'b1;
          skid_d   = '0;
          state_d  = ST_FETCH;
        end else if (pc_write) begin
          ifid_ld    = 1'b1;
          ifid_instr = skid_q;
          pc_d       = pc_plus4;
          state_d    = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (redirect_valid) begin
          pc_d     = redir_tgt;
          ifid_clr = 1'b1;
          skid_d   = '0;
          state_d  = ST_FETCH;
        end else if (imem_rvalid) begin
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id (
    .clk_i  (clk),
    .rst_ni (rst),
    .ld_i   (ifid_ld),
    .clr_i  (ifid_clr),
    .instr_i(ifid_instr),
    .pc4_i  (pc_plus4),
    .instr_o(if_id_instruction),
    .pc4_o  (if_id_pc_plus4),
    .valid_o(if_id_valid)
  );

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: boot, fetch, stall/skid, redirect
// (with and without same-cycle response), PC wrap and asynchronous reset.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_stage #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_write         (pc_write),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .pc_out           (pc_out),
    .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    pc_write       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;

    // 1: reset, then one idle cycle before the first request
    tick; tick;
    chk("rst_pc",    pc_out, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_instr", if_id_instruction, 32'h0);
    rst = 1'b1;
    #1 chk("boot_req", {31'b0, imem_req}, 32'h0);
    tick;
    chk("first_req",  {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    // 2: basic fetch
    imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    tick;
    imem_rvalid = 1'b0;
    chk("f0_instr", if_id_instruction, 32'h2008_0005);
    chk("f0_pc4",   if_id_pc_plus4, 32'h4);
    chk("f0_valid", {31'b0, if_id_valid}, 32'h1);
    chk("f0_pc",    pc_out, 32'h4);
    chk("f0_req",   {31'b0, imem_req}, 32'h1);
    chk("f0_addr",  imem_addr, 32'h4);
    imem_rvalid = 1'b1; imem_rdata = 32'h0123_4567;
    tick;
    imem_rvalid = 1'b0;
    chk("f1_instr", if_id_instruction, 32'h0123_4567);
    chk("f1_addr",  imem_addr, 32'h8);

    // 3: stall on response -> HOLD; spurious rvalid ignored
    imem_rvalid = 1'b1; imem_rdata = 32'h0109_5020; pc_write = 1'b0;
    tick;
    imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_req",   {31'b0, imem_req}, 32'h0);
      chk("hold_instr", if_id_instruction, 32'h0123_4567);
      chk("hold_pc",    pc_out, 32'h8);
      if (i == 1) begin imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; end
      tick;
      imem_rvalid = 1'b0;
    end
    pc_write = 1'b1;
    tick;
    chk("rel_instr", if_id_instruction, 32'h0109_5020);
    chk("rel_pc4",   if_id_pc_plus4, 32'hC);
    chk("rel_pc",    pc_out, 32'hC);
    chk("rel_req",   {31'b0, imem_req}, 32'h1);

    // 4: redirect while waiting -> DRAIN, stale response discarded
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick;
    redirect_valid = 1'b0;
    chk("rd_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rd_instr", if_id_instruction, 32'h0);
    chk("rd_pc",    pc_out, 32'h40);
    chk("rd_req",   {31'b0, imem_req}, 32'h0);
    tick;
    chk("drain_req", {31'b0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_rvalid = 1'b0;
    chk("drain_valid", {31'b0, if_id_valid}, 32'h0);
    chk("drain_req2",  {31'b0, imem_req}, 32'h1);
    chk("drain_addr",  imem_addr, 32'h40);

    // 5: redirect with same-cycle rvalid and stall: no HOLD, target aligned
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_5555; pc_write = 1'b0;
    tick;
    redirect_valid = 1'b0; imem_rvalid = 1'b0; pc_write = 1'b1;
    chk("rs_req",   {31'b0, imem_req}, 32'h1);
    chk("rs_addr",  imem_addr, 32'h40);
    chk("rs_valid", {31'b0, if_id_valid}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
    tick;
    imem_rvalid = 1'b0;
    chk("rs_instr", if_id_instruction, 32'h1111_2222);
    chk("rs_pc4",   if_id_pc_plus4, 32'h44);

    // 6: PC wrap, then async reset mid-request
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0;
    tick;
    imem_rvalid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_3333;
    tick;
    imem_rvalid = 1'b0;
    chk("wrap_pc",    pc_out, 32'h0);
    chk("wrap_pc4",   if_id_pc_plus4, 32'h0);
    chk("wrap_instr", if_id_instruction, 32'h2222_3333);
    chk("wrap_req",   {31'b0, imem_req}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_instr", if_id_instruction, 32'h0);
    chk("arst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("arst_req",   {31'b0, imem_req}, 32'h0);
    chk("arst_pc",    pc_out, 32'h0);
    tick;
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
